// File: rtl/prediction_buffer_controller.sv
// Ping-pong sequencer for the completed-prediction RAM: 16-bit macroblock writes into one bank
// while the other bank drains as an 8-bit valid/ready byte stream.
module prediction_buffer_controller #(
  parameter int unsigned WORDS_PER_MB = 192
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        Flush_I,
  input  logic        Pred_Valid_I,
  input  logic [15:0] Pred_Data_I,
  output logic        Pred_Ready_O,
  output logic        Buf_Write_En_O,
  output logic [9:0]  Buf_Write_Address_O,
  output logic [15:0] Buf_Write_Data_O,
  output logic [10:0] Buf_Read_Address_O,
  input  logic [7:0]  Buf_Read_Data_I,
  output logic        Out_Valid_O,
  output logic [7:0]  Out_Data_O,
  output logic        Out_Last_O,
  input  logic        Out_Ready_I,
  output logic        MB_Written_O,
  output logic        MB_Read_O
);

  localparam int unsigned BYTES_PER_MB = 2 * WORDS_PER_MB;
  localparam logic [8:0]  WordLast     = 9'(WORDS_PER_MB - 1);
  localparam logic [9:0]  ByteLast     = 10'(BYTES_PER_MB - 1);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull, StDraining} bank_state_e;

  typedef struct packed {
    logic       bank;
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic [8:0]  wcnt_q, wcnt_d;
  logic [9:0]  rcnt_q, rcnt_d;
  logic [10:0] rd_addr_q, rd_addr_d;
  logic        pend_q, pend_d;
  logic        pend_last_q, pend_last_d;
  logic        pend_bank_q, pend_bank_d;
  fifo_entry_t fifo_q [2];
  fifo_entry_t fifo_d [2];
  logic        fifo_wptr_q, fifo_wptr_d;
  logic        fifo_rptr_q, fifo_rptr_d;
  logic [1:0]  fifo_count_q, fifo_count_d;
  logic        mb_written_q, mb_written_d;
  logic        mb_read_q, mb_read_d;

  logic        accept, wr_last, rd_ok, issue, rd_last, pop, pop_last;
  logic [2:0]  occupancy;
  fifo_entry_t head;

  assign head         = fifo_q[fifo_rptr_q];
  assign Pred_Ready_O = (bank_q[wr_bank_q] == StEmpty) || (bank_q[wr_bank_q] == StFilling);
  assign accept       = Pred_Valid_I & Pred_Ready_O;
  assign wr_last      = (wcnt_q == WordLast);

  assign Out_Valid_O  = (fifo_count_q != 2'd0);
  assign pop          = Out_Valid_O & Out_Ready_I;
  assign pop_last     = pop & head.last;

  assign rd_ok        = (bank_q[rd_bank_q] == StFull) || (bank_q[rd_bank_q] == StDraining);
  // Bytes still owed a FIFO slot after this cycle's pop; an issue needs one more free slot.
  assign occupancy    = 3'(fifo_count_q) + 3'(pend_q) - 3'(pop);
  assign issue        = rd_ok && (occupancy < 3'd2);
  assign rd_last      = (rcnt_q == ByteLast);

  assign Buf_Write_En_O      = accept;
  assign Buf_Write_Address_O = {wr_bank_q, wcnt_q};
  assign Buf_Write_Data_O    = accept ? Pred_Data_I : 16'h0000;
  assign Buf_Read_Address_O  = issue ? {rd_bank_q, rcnt_q} : rd_addr_q;
  assign Out_Data_O          = head.data;
  assign Out_Last_O          = Out_Valid_O & head.last;
  assign MB_Written_O        = mb_written_q;
  assign MB_Read_O           = mb_read_q;

  always_comb begin
    bank_d       = bank_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wcnt_d       = wcnt_q;
    rcnt_d       = rcnt_q;
    rd_addr_d    = rd_addr_q;
    pend_d       = issue;
    pend_last_d  = pend_last_q;
    pend_bank_d  = pend_bank_q;
    fifo_d       = fifo_q;
    fifo_wptr_d  = fifo_wptr_q;
    fifo_rptr_d  = fifo_rptr_q;
    fifo_count_d = fifo_count_q + 2'(pend_q) - 2'(pop);
    mb_written_d = accept & wr_last;
    mb_read_d    = pop_last;

    if (accept) begin
      bank_d[wr_bank_q] = wr_last ? StFull : StFilling;
      wcnt_d            = wr_last ? 9'd0 : wcnt_q + 9'd1;
      if (wr_last) wr_bank_d = ~wr_bank_q;
    end

    if (issue) begin
      bank_d[rd_bank_q] = StDraining;
      rd_addr_d         = {rd_bank_q, rcnt_q};
      pend_last_d       = rd_last;
      pend_bank_d       = rd_bank_q;
      rcnt_d            = rd_last ? 10'd0 : rcnt_q + 10'd1;
      if (rd_last) rd_bank_d = ~rd_bank_q;
    end

    // RAM data for last cycle's issue lands now.
    if (pend_q) begin
      fifo_d[fifo_wptr_q] = {pend_bank_q, pend_last_q, Buf_Read_Data_I};
      fifo_wptr_d         = ~fifo_wptr_q;
    end

    if (pop) begin
      fifo_rptr_d = ~fifo_rptr_q;
      if (pop_last) bank_d[head.bank] = StEmpty;
    end

    if (Flush_I) begin
      bank_d[0]    = StEmpty;
      bank_d[1]    = StEmpty;
      wr_bank_d    = 1'b0;
      rd_bank_d    = 1'b0;
      wcnt_d       = 9'd0;
      rcnt_d       = 10'd0;
      rd_addr_d    = 11'd0;
      pend_d       = 1'b0;
      pend_last_d  = 1'b0;
      pend_bank_d  = 1'b0;
      fifo_d[0]    = '0;
      fifo_d[1]    = '0;
      fifo_wptr_d  = 1'b0;
      fifo_rptr_d  = 1'b0;
      fifo_count_d = 2'd0;
      mb_written_d = 1'b0;
      mb_read_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bank_q[0]    <= StEmpty;
      bank_q[1]    <= StEmpty;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wcnt_q       <= 9'd0;
      rcnt_q       <= 10'd0;
      rd_addr_q    <= 11'd0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      pend_bank_q  <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      fifo_wptr_q  <= 1'b0;
      fifo_rptr_q  <= 1'b0;
      fifo_count_q <= 2'd0;
      mb_written_q <= 1'b0;
      mb_read_q    <= 1'b0;
    end else begin
      bank_q       <= bank_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      rd_addr_q    <= rd_addr_d;
      pend_q       <= pend_d;
      pend_last_q  <= pend_last_d;
      pend_bank_q  <= pend_bank_d;
      fifo_q       <= fifo_d;
      fifo_wptr_q  <= fifo_wptr_d;
      fifo_rptr_q  <= fifo_rptr_d;
      fifo_count_q <= fifo_count_d;
      mb_written_q <= mb_written_d;
      mb_read_q    <= mb_read_d;
    end
  end

  // Writer and reader must never touch the same bank in one cycle.
  assert property (@(posedge clock) disable iff (!resetn)
    !(accept && issue && (wr_bank_q == rd_bank_q)));

  assert property (@(posedge clock) disable iff (!resetn)
    !(pend_q && (fifo_count_q == 2'd2) && !pop));

endmodule

// File: tb/tb_prediction_buffer_controller.sv
// Directed bench for prediction_buffer_controller: a 192-word instance and a 4-word instance,
// each backed by a 1024x16 / 2048x8 RAM model.
module tb_prediction_buffer_controller;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  // Instance A: WORDS_PER_MB = 192
  logic        a_flush = 1'b0, a_pv = 1'b0, a_ordy = 1'b0;
  logic [15:0] a_pd = 16'h0;
  logic        a_prdy, a_we, a_ov, a_ol, a_mbw, a_mbr;
  logic [9:0]  a_waddr;
  logic [15:0] a_wdata;
  logic [10:0] a_raddr;
  logic [7:0]  a_rdata, a_od;
  logic [15:0] a_mem [1024];

  prediction_buffer_controller #(.WORDS_PER_MB(192)) u_dut_a (
    .clock               (clock),
    .resetn              (resetn),
    .Flush_I             (a_flush),
    .Pred_Valid_I        (a_pv),
    .Pred_Data_I         (a_pd),
    .Pred_Ready_O        (a_prdy),
    .Buf_Write_En_O      (a_we),
    .Buf_Write_Address_O (a_waddr),
    .Buf_Write_Data_O    (a_wdata),
    .Buf_Read_Address_O  (a_raddr),
    .Buf_Read_Data_I     (a_rdata),
    .Out_Valid_O         (a_ov),
    .Out_Data_O          (a_od),
    .Out_Last_O          (a_ol),
    .Out_Ready_I         (a_ordy),
    .MB_Written_O        (a_mbw),
    .MB_Read_O           (a_mbr)
  );

  always @(posedge clock) begin
    if (a_we) a_mem[a_waddr] <= a_wdata;
    a_rdata <= a_raddr[0] ? a_mem[a_raddr[10:1]][15:8] : a_mem[a_raddr[10:1]][7:0];
  end

  // Instance B: WORDS_PER_MB = 4
  logic        b_flush = 1'b0, b_pv = 1'b0, b_ordy = 1'b0;
  logic [15:0] b_pd = 16'h0;
  logic        b_prdy, b_we, b_ov, b_ol, b_mbw, b_mbr;
  logic [9:0]  b_waddr;
  logic [15:0] b_wdata;
  logic [10:0] b_raddr;
  logic [7:0]  b_rdata, b_od;
  logic [15:0] b_mem [1024];

  prediction_buffer_controller #(.WORDS_PER_MB(4)) u_dut_b (
    .clock               (clock),
    .resetn              (resetn),
    .Flush_I             (b_flush),
    .Pred_Valid_I        (b_pv),
    .Pred_Data_I         (b_pd),
    .Pred_Ready_O        (b_prdy),
    .Buf_Write_En_O      (b_we),
    .Buf_Write_Address_O (b_waddr),
    .Buf_Write_Data_O    (b_wdata),
    .Buf_Read_Address_O  (b_raddr),
    .Buf_Read_Data_I     (b_rdata),
    .Out_Valid_O         (b_ov),
    .Out_Data_O          (b_od),
    .Out_Last_O          (b_ol),
    .Out_Ready_I         (b_ordy),
    .MB_Written_O        (b_mbw),
    .MB_Read_O           (b_mbr)
  );

  always @(posedge clock) begin
    if (b_we) b_mem[b_waddr] <= b_wdata;
    b_rdata <= b_raddr[0] ? b_mem[b_raddr[10:1]][15:8] : b_mem[b_raddr[10:1]][7:0];
  end

  // Logs filled by the steppers
  logic [9:0] a_wq [$];
  logic [7:0] a_bq [$];
  logic       a_lq [$];
  int         a_nw, a_nr, a_cyc, a_first_ov, a_hold_bad;
  logic       a_acc, a_prev_stall, a_prev_ol;
  logic [7:0] a_prev_od;

  logic [9:0] b_wq [$];
  logic [7:0] b_bq [$];
  logic       b_lq [$];
  int         b_nw, b_nr;
  logic       b_acc;

  function automatic logic [15:0] word(input int k);
    return {8'(2 * k + 1), 8'(2 * k)};
  endfunction

  function automatic logic [15:0] fword(input int k);
    return {8'(2 * k + 1) ^ 8'h5A, 8'(2 * k) ^ 8'h5A};
  endfunction

  task automatic a_clear();
    a_wq.delete(); a_bq.delete(); a_lq.delete();
    a_nw = 0; a_nr = 0; a_cyc = 0; a_first_ov = -1; a_hold_bad = 0;
    a_acc = 1'b0; a_prev_stall = 1'b0; a_prev_od = 8'h0; a_prev_ol = 1'b0;
  endtask

  task automatic b_clear();
    b_wq.delete(); b_bq.delete(); b_lq.delete();
    b_nw = 0; b_nr = 0; b_acc = 1'b0;
  endtask

  // Drive one cycle of A at the falling edge, then sample just after.
  task automatic a_step(input logic pv, input logic [15:0] pd, input logic ordy, input logic fl);
    @(negedge clock);
    a_pv = pv; a_pd = pd; a_ordy = ordy; a_flush = fl;
    #1;
    a_acc = pv && a_prdy;
    if (a_we) a_wq.push_back(a_waddr);
    if (a_prev_stall && (!a_ov || a_od !== a_prev_od || a_ol !== a_prev_ol)) a_hold_bad++;
    a_prev_stall = a_ov && !ordy;
    a_prev_od    = a_od;
    a_prev_ol    = a_ol;
    if (a_ov && ordy) begin
      a_bq.push_back(a_od);
      a_lq.push_back(a_ol);
    end
    if (a_ov && a_first_ov < 0) a_first_ov = a_cyc;
    if (a_mbw) a_nw++;
    if (a_mbr) a_nr++;
    a_cyc++;
  endtask

  task automatic b_step(input logic pv, input logic [15:0] pd, input logic ordy);
    @(negedge clock);
    b_pv = pv; b_pd = pd; b_ordy = ordy;
    #1;
    b_acc = pv && b_prdy;
    if (b_we) b_wq.push_back(b_waddr);
    if (b_ov && ordy) begin
      b_bq.push_back(b_od);
      b_lq.push_back(b_ol);
    end
    if (b_mbw) b_nw++;
    if (b_mbr) b_nr++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    a_pv = 1'b0; a_pd = 16'h0; a_ordy = 1'b0; a_flush = 1'b0;
    b_pv = 1'b0; b_pd = 16'h0; b_ordy = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    a_clear();
    b_clear();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    compared++;
    if (a_prdy !== 1'b1) begin mismatched++; $display("FAIL reset_pred_ready: got %b want 1", a_prdy); end
    compared++;
    if (a_we !== 1'b0) begin mismatched++; $display("FAIL reset_write_en: got %b want 0", a_we); end
    compared++;
    if (a_ov !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", a_ov); end
    compared++;
    if (a_raddr !== 11'd0) begin mismatched++; $display("FAIL reset_read_addr: got %0d want 0", a_raddr); end
    compared++;
    if ({a_ol, a_mbw, a_mbr} !== 3'b000) begin
      mismatched++; $display("FAIL reset_pulses: got %b want 000", {a_ol, a_mbw, a_mbr});
    end
    compared++;
    if (b_prdy !== 1'b1) begin mismatched++; $display("FAIL reset_small_ready: got %b want 1", b_prdy); end
  endtask

  task automatic test_single_mb();
    int k = 0;
    int guard = 0;
    int t_last = -1;
    int bad = 0;
    do_reset();
    while (a_bq.size() < 384 && guard < 2000) begin
      a_step(k < 192, word(k), 1'b1, 1'b0);
      if (a_acc) begin
        if (k == 191) t_last = a_cyc - 1;
        k++;
      end
      guard++;
    end
    repeat (3) a_step(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < a_wq.size(); i++) if (a_wq[i] !== 10'(i)) bad++;
    compared++;
    if (a_wq.size() != 192 || bad != 0) begin
      mismatched++; $display("FAIL single_waddr: got %0d writes %0d bad want 192 0", a_wq.size(), bad);
    end
    bad = 0;
    for (int j = 0; j < a_bq.size(); j++) if (a_bq[j] !== 8'(j)) bad++;
    compared++;
    if (a_bq.size() != 384 || bad != 0) begin
      mismatched++; $display("FAIL single_bytes: got %0d bytes %0d bad want 384 0", a_bq.size(), bad);
    end
    bad = 0;
    for (int j = 0; j < a_lq.size(); j++) if (a_lq[j] !== (j == 383)) bad++;
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL single_last: got %0d bad want 0", bad); end
    compared++;
    if (a_nw != 1 || a_nr != 1) begin
      mismatched++; $display("FAIL single_pulses: got written %0d read %0d want 1 1", a_nw, a_nr);
    end
    compared++;
    if (a_first_ov != t_last + 3) begin
      mismatched++; $display("FAIL single_latency: got %0d want %0d", a_first_ov, t_last + 3);
    end
  endtask

  task automatic test_ping_pong();
    int k = 0;
    int guard = 0;
    int bad = 0;
    int sz;
    int l_cyc = -1;
    int r_cyc = -1;
    logic prdy_at_l = 1'b1;
    do_reset();
    repeat (450) begin
      a_step(k < 576, word(k), 1'b0, 1'b0);
      if (a_acc) k++;
    end
    compared++;
    if (k != 384) begin mismatched++; $display("FAIL pp_accepted: got %0d want 384", k); end
    compared++;
    if (a_prdy !== 1'b0) begin mismatched++; $display("FAIL pp_ready_stalled: got %b want 0", a_prdy); end
    for (int i = 0; i < a_wq.size(); i++)
      if (a_wq[i] !== ((i < 192) ? 10'(i) : 10'(512 + i - 192))) bad++;
    compared++;
    if (a_wq.size() != 384 || bad != 0) begin
      mismatched++; $display("FAIL pp_waddr: got %0d writes %0d bad want 384 0", a_wq.size(), bad);
    end
    while (a_bq.size() < 1152 && guard < 3000) begin
      sz = a_bq.size();
      a_step(k < 576, word(k), 1'b1, 1'b0);
      if (a_acc) k++;
      if (l_cyc < 0 && a_bq.size() > sz && a_lq[$]) begin
        l_cyc = a_cyc - 1;
        prdy_at_l = a_prdy;
      end else if (l_cyc >= 0 && r_cyc < 0 && a_prdy) begin
        r_cyc = a_cyc - 1;
      end
      guard++;
    end
    compared++;
    if (l_cyc < 0 || r_cyc != l_cyc + 1 || prdy_at_l !== 1'b0) begin
      mismatched++;
      $display("FAIL pp_ready_return: got ready at %0d (last pop %0d, ready then %b) want %0d",
               r_cyc, l_cyc, prdy_at_l, l_cyc + 1);
    end
    bad = 0;
    for (int j = 0; j < a_bq.size(); j++)
      if (a_bq[j] !== 8'(j) || a_lq[j] !== (j % 384 == 383)) bad++;
    compared++;
    if (a_bq.size() != 1152 || bad != 0) begin
      mismatched++; $display("FAIL pp_bytes: got %0d bytes %0d bad want 1152 0", a_bq.size(), bad);
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    int guard = 0;
    int bad = 0;
    logic [15:0] lfsr = 16'hACE1;
    do_reset();
    while (a_bq.size() < 768 && guard < 6000) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      a_step(k < 384, word(k), lfsr[0], 1'b0);
      if (a_acc) k++;
      guard++;
    end
    for (int j = 0; j < a_bq.size(); j++)
      if (a_bq[j] !== 8'(j) || a_lq[j] !== (j % 384 == 383)) bad++;
    compared++;
    if (a_bq.size() != 768 || bad != 0) begin
      mismatched++; $display("FAIL bp_bytes: got %0d bytes %0d bad want 768 0", a_bq.size(), bad);
    end
    compared++;
    if (a_hold_bad != 0) begin mismatched++; $display("FAIL bp_hold: got %0d unstable want 0", a_hold_bad); end
  endtask

  task automatic test_flush();
    int k = 0;
    int guard = 0;
    int bad = 0;
    do_reset();
    while (k < 192 && guard < 1000) begin
      a_step(1'b1, word(k), 1'b0, 1'b0);
      if (a_acc) k++;
      guard++;
    end
    while ((k < 292 || a_bq.size() < 50) && guard < 2000) begin
      a_step(k < 292, word(k), a_bq.size() < 50, 1'b0);
      if (a_acc) k++;
      guard++;
    end
    a_step(1'b0, 16'h0, 1'b0, 1'b1);
    a_step(1'b1, fword(0), 1'b0, 1'b0);
    compared++;
    if (a_prdy !== 1'b1 || a_ov !== 1'b0) begin
      mismatched++; $display("FAIL flush_state: got ready %b valid %b want 1 0", a_prdy, a_ov);
    end
    compared++;
    if (a_we !== 1'b1 || a_waddr !== 10'd0) begin
      mismatched++; $display("FAIL flush_waddr: got en %b addr %0d want 1 0", a_we, a_waddr);
    end
    k = a_acc ? 1 : 0;
    a_bq.delete();
    a_lq.delete();
    guard = 0;
    while (a_bq.size() < 384 && guard < 2000) begin
      a_step(k < 192, fword(k), 1'b1, 1'b0);
      if (a_acc) k++;
      guard++;
    end
    for (int j = 0; j < a_bq.size(); j++)
      if (a_bq[j] !== (8'(j) ^ 8'h5A) || a_lq[j] !== (j == 383)) bad++;
    compared++;
    if (a_bq.size() != 384 || bad != 0) begin
      mismatched++; $display("FAIL flush_fresh_mb: got %0d bytes %0d bad want 384 0", a_bq.size(), bad);
    end
  endtask

  task automatic test_async_reset();
    int k = 0;
    int guard = 0;
    do_reset();
    while (k < 384 && guard < 1000) begin
      a_step(1'b1, word(k), 1'b0, 1'b0);
      if (a_acc) k++;
      guard++;
    end
    repeat (4) a_step(1'b1, word(k), 1'b0, 1'b0);
    compared++;
    if (a_prdy !== 1'b0 || a_ov !== 1'b1 || a_raddr !== 11'd1) begin
      mismatched++;
      $display("FAIL areset_pre: got ready %b valid %b raddr %0d want 0 1 1", a_prdy, a_ov, a_raddr);
    end
    #1;
    resetn = 1'b0;
    #1;
    compared++;
    if (a_prdy !== 1'b1 || a_ov !== 1'b0) begin
      mismatched++; $display("FAIL areset_handshake: got ready %b valid %b want 1 0", a_prdy, a_ov);
    end
    compared++;
    if (a_raddr !== 11'd0 || {a_ol, a_mbw, a_mbr} !== 3'b000) begin
      mismatched++;
      $display("FAIL areset_outputs: got raddr %0d pulses %b want 0 000", a_raddr, {a_ol, a_mbw, a_mbr});
    end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_small_param();
    int k = 0;
    int guard = 0;
    int bad = 0;
    do_reset();
    while (b_bq.size() < 48 && guard < 500) begin
      b_step(k < 24, word(k), 1'b1);
      if (b_acc) k++;
      guard++;
    end
    repeat (3) b_step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < b_wq.size(); i++)
      if (b_wq[i] !== 10'(((i / 4) % 2) * 512 + i % 4)) bad++;
    compared++;
    if (b_wq.size() != 24 || bad != 0) begin
      mismatched++; $display("FAIL small_waddr: got %0d writes %0d bad want 24 0", b_wq.size(), bad);
    end
    bad = 0;
    for (int j = 0; j < b_bq.size(); j++)
      if (b_bq[j] !== 8'(j) || b_lq[j] !== (j % 8 == 7)) bad++;
    compared++;
    if (b_bq.size() != 48 || bad != 0) begin
      mismatched++; $display("FAIL small_bytes: got %0d bytes %0d bad want 48 0", b_bq.size(), bad);
    end
    compared++;
    if (b_nw != 6 || b_nr != 6) begin
      mismatched++; $display("FAIL small_pulses: got written %0d read %0d want 6 6", b_nw, b_nr);
    end
  endtask

  initial begin
    a_clear();
    b_clear();
    test_reset();
    test_single_mb();
    test_ping_pong();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_small_param();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/prediction_buffer_controller.md
Name: prediction_buffer_controller

Overview:
- Sequencer for the 1024x16 write / 2048x8 read completed-prediction RAM in motion compensation.
- Splits the RAM into two ping-pong banks. Bank select is write address bit 9 and read address bit 10.
- Accepts one macroblock of 16-bit pixel pairs from the prediction adder while the reconstruction side drains the other bank byte-wise.
- Guarantees the write and read ports never address the same bank concurrently, and hides the RAM's 1-cycle read latency behind a valid/ready byte stream.

Parameters:
WORDS_PER_MB, 192, 16-bit words per macroblock (384 bytes, 4:2:0); legal range 2..512
BYTES_PER_MB, 2*WORDS_PER_MB, derived; not overridable

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
Flush_I  input  1  synchronous clear of all banks and pipelines (sequence or picture abort)
Pred_Valid_I  input  1  pixel-pair word offered
Pred_Data_I  input  16  pixel pair; [7:0] is the earlier byte
Pred_Ready_O  output  1  word accepted when Pred_Valid_I & Pred_Ready_O
Buf_Write_En_O  output  1  RAM 16-bit port write enable
Buf_Write_Address_O  output  10  {write bank, word index[8:0]}
Buf_Write_Data_O  output  16  RAM write data
Buf_Read_Address_O  output  11  {read bank, byte index[9:0]}
Buf_Read_Data_I  input  8  RAM 8-bit port data, valid 1 cycle after address
Out_Valid_O  output  1  byte available
Out_Data_O  output  8  byte
Out_Last_O  output  1  final byte of the macroblock
Out_Ready_I  input  1  consumer accepts when Out_Valid_O & Out_Ready_I
MB_Written_O  output  1  1-cycle pulse when a bank becomes FULL
MB_Read_O  output  1  1-cycle pulse when a bank returns to EMPTY

Behaviour:
- Reset (resetn=0, asynchronous):
  - Both banks EMPTY; wr_bank=0, rd_bank=0; counters=0; FIFO and pending read cleared.
  - All outputs 0 except Pred_Ready_O=1.
  - Buf_Read_Address_O=0.
- Flush_I=1 at an edge: identical state to reset, taking effect on the next edge. Flush has priority over every other event in that cycle. A Buf_Read_Data_I byte returning after a flush is discarded.
- Per-bank state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - Pred_Ready_O = bank[wr_bank] in EMPTY or FILLING; this is combinational from registered state.
  - On accept, in the same cycle: Buf_Write_En_O=1, address {wr_bank, wcnt}, data=Pred_Data_I. Write is combinational pass-through, zero latency.
  - wcnt increments on each accept.
  - On the accept with wcnt==WORDS_PER_MB-1: bank becomes FULL, wcnt->0, wr_bank toggles, and MB_Written_O pulses the next cycle.
  - When both banks are FULL or DRAINING, Pred_Ready_O=0.
- Read side:
  - Issue a RAM read when bank[rd_bank] is FULL or DRAINING and (fifo_count + pend - pop) < 2, where pop = Out_Valid_O & Out_Ready_I.
  - On issue: address {rd_bank, rcnt}, pend<=1, rcnt++, and bank goes DRAINING.
  - One cycle later, Buf_Read_Data_I is pushed into a 2-entry output FIFO, tagged last if it was byte BYTES_PER_MB-1.
  - Buf_Read_Address_O holds its last value when no read is issued.
  - After issuing byte BYTES_PER_MB-1: rcnt->0, rd_bank toggles, and the bank is marked EMPTY when its last byte is popped. MB_Read_O pulses the cycle after that pop.
  - Sustained throughput is 1 byte/cycle with Out_Ready_I=1.
  - First Out_Valid_O comes 2 cycles after the bank becomes FULL: 1 cycle for the FULL register, 1 for RAM latency.
- Byte order: word w maps to bytes 2w (Pred_Data_I[7:0]) and 2w+1 ([15:8]); this matches RAM port width mapping.
- Simultaneous events in one cycle:
  - A write completion on one bank and a read completion on the other are both honoured.
  - A bank returning EMPTY in a cycle does not assert Pred_Ready_O for that bank until the next cycle.
- Out_Valid_O / Out_Data_O / Out_Last_O stay stable while Out_Valid_O=1 and Out_Ready_I=0.
- Invariant: the write and read banks never refer to the same bank while it is FILLING and DRAINING respectively; assert this in simulation.

Test Plan:
- Single MB:
  - Stimulus: reset, then 192 words, word k = {2k+1, 2k} (mod 256), Out_Ready_I=1.
  - Writes go to addresses 0..191; MB_Written_O pulses once.
  - Bytes 0..383 come out in order, ascending, with Out_Last_O only on byte 383, then MB_Read_O.
- Ping-pong stall:
  - Stimulus: Out_Ready_I=0, offer 3 MBs continuously.
  - Words 0-383 are accepted, with the second MB at addresses 512..703; Pred_Ready_O=0 from word 384 onward.
  - Raise Out_Ready_I: Pred_Ready_O returns to 1 the cycle after bank 0's last byte is popped.
- Backpressure:
  - Stimulus: Out_Ready_I toggling with a pseudo-random pattern.
  - No bytes lost or duplicated; output holds stable while stalled; scoreboard matches the written data.
- Flush mid-operation:
  - Stimulus: assert Flush_I after 100 words written and 50 bytes read.
  - Next cycle: Pred_Ready_O=1, Out_Valid_O=0, Buf_Write_Address_O restarts at 0.
  - A fresh MB then reads back correctly.
- Async reset:
  - Stimulus: drop resetn between clock edges while DRAINING.
  - Outputs go to reset values immediately, with no clock edge required.
- Small parameter:
  - Stimulus: WORDS_PER_MB=4, 6 MBs back-to-back with Out_Ready_I=1.
  - Bank alternation follows 0,512,0,512…; 48 bytes out, Out_Last_O every 8th byte.
